// File: rtl/window_router.sv
// window_router: copies a contiguous address window out of a local buffer
// and emits it as a stream of beats, up to MaxWidth elements per beat
// with lane 0 at the LSBs.
// Optional feature: define ROUTER_WRAP_EN to let a route whose finalAddr
// lies below its startAddr wrap around the end of the buffer. Without it,
// such a request is rejected with an error pulse.
module window_router #(
    parameter int DataWidth = 8,
    parameter int Depth     = 128,
    parameter int MaxWidth  = 9,
    localparam int AddrWidth = $clog2(Depth),
    localparam int CntWidth  = $clog2(MaxWidth + 1)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          writeEn,
    input  logic [AddrWidth-1:0]          writeAddr,
    input  logic [DataWidth-1:0]          dataIn,
    input  logic                          routeEn,
    input  logic [AddrWidth-1:0]          startAddr,
    input  logic [AddrWidth-1:0]          finalAddr,
    input  logic [CntWidth-1:0]           laneCount,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [MaxWidth*DataWidth-1:0] dataOut,
    output logic                          outLast,
    output logic                          busy,
    output logic                          finished,
    output logic                          error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CntWidth-1:0]  CntZero = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0]  CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [AddrWidth:0]   LenZero = {(AddrWidth+1){1'b0}};
    localparam logic [AddrWidth:0]   LenOne  = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] AddrOne = {{(AddrWidth-1){1'b0}}, 1'b1};

    logic [DataWidth-1:0]          mem [Depth];
    logic [DataWidth-1:0]          rdData_r;
    state_t                        state_r;
    state_t                        nextState_s;
    logic [AddrWidth-1:0]          curAddr_r;
    logic [AddrWidth-1:0]          nextAddr_s;
    logic [AddrWidth:0]            remain_r;
    logic [AddrWidth:0]            routeLen_s;
    logic [CntWidth-1:0]           laneCnt_r;
    logic [CntWidth-1:0]           issueCnt_r;
    logic [CntWidth-1:0]           capIdx_r;
    logic                          rdValid_r;
    logic [MaxWidth*DataWidth-1:0] beat_r;
    logic                          outValid_r;
    logic                          outLast_r;
    logic                          busy_r;
    logic                          finished_r;
    logic                          error_r;
    logic                          reqBad_s;
    logic                          accept_s;
    logic                          issue_s;
    logic                          handshake_s;

    // Buffer write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= dataIn;
        end
    end

    // Synchronous read; a same-cycle write to this address yields the old data.
    always_ff @(posedge clk) begin
        rdData_r <= mem[curAddr_r];
    end

    // Request validation, route length and read-address increment.
    always_comb begin
`ifdef ROUTER_WRAP_EN
        reqBad_s = (laneCount == CntZero) || (laneCount > CntWidth'(MaxWidth));
        if (finalAddr >= startAddr) begin
            routeLen_s = {1'b0, finalAddr} - {1'b0, startAddr};
        end else begin
            routeLen_s = (AddrWidth+1)'(Depth) - {1'b0, startAddr} + {1'b0, finalAddr};
        end
`else
        reqBad_s = (laneCount == CntZero) || (laneCount > CntWidth'(MaxWidth)) ||
                   (finalAddr < startAddr);
        routeLen_s = {1'b0, finalAddr} - {1'b0, startAddr};
`endif
        if (curAddr_r == AddrWidth'(Depth - 1)) begin
            nextAddr_s = {AddrWidth{1'b0}};
        end else begin
            nextAddr_s = curAddr_r + AddrOne;
        end
        accept_s    = (state_r == IDLE) && routeEn && !reqBad_s;
        issue_s     = (state_r == READ) && (issueCnt_r < laneCnt_r) && (remain_r != LenZero);
        handshake_s = (state_r == OUT) && outValid_r && outReady;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic; READ includes one drain cycle for the read latency.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    nextState_s = (routeLen_s == LenZero) ? DONE : READ;
                end else begin
                    nextState_s = IDLE;
                end
            end
            READ: begin
                nextState_s = issue_s ? READ : OUT;
            end
            OUT: begin
                if (handshake_s) begin
                    nextState_s = (remain_r == LenZero) ? DONE : READ;
                end else begin
                    nextState_s = OUT;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Datapath: route bookkeeping, lane assembly and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            curAddr_r  <= {AddrWidth{1'b0}};
            remain_r   <= LenZero;
            laneCnt_r  <= CntZero;
            issueCnt_r <= CntZero;
            capIdx_r   <= CntZero;
            rdValid_r  <= 1'b0;
            beat_r     <= {(MaxWidth*DataWidth){1'b0}};
            outValid_r <= 1'b0;
            outLast_r  <= 1'b0;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rdValid_r  <= issue_s;
            outValid_r <= (nextState_s == OUT);
            busy_r     <= (nextState_s != IDLE);
            finished_r <= (nextState_s == DONE);
            error_r    <= (state_r == IDLE) && routeEn && reqBad_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        curAddr_r  <= startAddr;
                        remain_r   <= routeLen_s;
                        laneCnt_r  <= laneCount;
                        issueCnt_r <= CntZero;
                        capIdx_r   <= CntZero;
                        beat_r     <= {(MaxWidth*DataWidth){1'b0}};
                        outLast_r  <= 1'b0;
                    end
                end
                READ: begin
                    if (issue_s) begin
                        curAddr_r  <= nextAddr_s;
                        remain_r   <= remain_r - LenOne;
                        issueCnt_r <= issueCnt_r + CntOne;
                    end else begin
                        outLast_r <= (remain_r == LenZero);
                    end
                    if (rdValid_r) begin
                        for (int k = 0; k < MaxWidth; k++) begin
                            if (capIdx_r == CntWidth'(k)) begin
                                beat_r[k*DataWidth +: DataWidth] <= rdData_r;
                            end
                        end
                        capIdx_r <= capIdx_r + CntOne;
                    end
                end
                OUT: begin
                    if (handshake_s) begin
                        beat_r     <= {(MaxWidth*DataWidth){1'b0}};
                        issueCnt_r <= CntZero;
                        capIdx_r   <= CntZero;
                        outLast_r  <= 1'b0;
                    end
                end
                DONE: begin
                    outLast_r <= 1'b0;
                end
                default: begin
                    outLast_r <= 1'b0;
                end
            endcase
        end
    end

    assign outValid = outValid_r;
    assign dataOut  = beat_r;
    assign outLast  = outLast_r;
    assign busy     = busy_r;
    assign finished = finished_r;
    assign error    = error_r;

endmodule

// File: tb/tb_window_router.sv
// Self-checking bench for window_router: a table of route requests run
// through a beat scoreboard, plus a mid-route reset sequence.
module tb_window_router;

    localparam int DW = 8;
    localparam int DEPTH = 128;
    localparam int MW = 9;
    localparam int AW = 7;
    localparam int CW = 4;
    localparam int BW = MW * DW;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          writeEn = 1'b0;
    logic [AW-1:0] writeAddr = '0;
    logic [DW-1:0] dataIn = '0;
    logic          routeEn = 1'b0;
    logic [AW-1:0] startAddr = '0;
    logic [AW-1:0] finalAddr = '0;
    logic [CW-1:0] laneCount = '0;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [BW-1:0] dataOut;
    logic          outLast;
    logic          busy;
    logic          finished;
    logic          error;

    window_router dut (
        .clk(clk), .nrst(nrst),
        .writeEn(writeEn), .writeAddr(writeAddr), .dataIn(dataIn),
        .routeEn(routeEn), .startAddr(startAddr), .finalAddr(finalAddr),
        .laneCount(laneCount),
        .outValid(outValid), .outReady(outReady), .dataOut(dataOut),
        .outLast(outLast), .busy(busy), .finished(finished), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        int            lat;
    } beat_t;

    typedef struct {
        int            s;
        int            f;
        int            lanes;
        int            stall;
        int            poke;
        int            expBeats;
        int            expFin;
        int            expErr;
        bit            chkFirst;
        logic [BW-1:0] first;
    } vec_t;

    beat_t         expQ[$];
    vec_t          vecs[$];
    logic [DW-1:0] model [DEPTH];
    int            tests = 0;
    int            fails = 0;
    int            cycleCnt = 0;
    int            refCycle = 0;
    int            beatCnt = 0;
    int            finCnt = 0;
    int            errCnt = 0;
    logic [BW-1:0] firstData = '0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExpected(input int s, input int f, input int lanes);
        int len;
        int addr;
        int n;
        beat_t b;
        len = (f >= s) ? f - s : DEPTH - s + f;
        addr = s;
        while (len > 0) begin
            n = (len < lanes) ? len : lanes;
            b.data = '0;
            for (int k = 0; k < n; k++) begin
                b.data[k*DW +: DW] = model[addr];
                addr = (addr + 1) % DEPTH;
            end
            len = len - n;
            b.last = (len == 0);
            b.lat = n + 2;
            expQ.push_back(b);
        end
    endtask

    // Cycle counter used for output latency measurement.
    initial begin
        forever begin
            @(posedge clk);
            cycleCnt++;
        end
    end

    // Monitor: scoreboard compare, hold stability, latency, pulse counts.
    initial begin
        logic          prevValid;
        logic          holdPrev;
        logic [BW-1:0] prevData;
        logic          prevLast;
        beat_t         b;
        prevValid = 1'b0;
        holdPrev = 1'b0;
        prevData = '0;
        prevLast = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                holdPrev = 1'b0;
                prevValid = 1'b0;
            end else begin
                if (holdPrev) begin
                    check("hold-valid", BW'(outValid), BW'(1'b1));
                    check("hold-data", dataOut, prevData);
                    check("hold-last", BW'(outLast), BW'(prevLast));
                end
                if (routeEn && !busy) refCycle = cycleCnt;
                if (outValid && !prevValid && expQ.size() > 0)
                    check("latency", BW'(cycleCnt - refCycle), BW'(expQ[0].lat));
                if (outValid && outReady) begin
                    if (beatCnt == 0) firstData = dataOut;
                    beatCnt++;
                    refCycle = cycleCnt;
                    if (expQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL beat-unexpected: got %0h, no beat expected", dataOut);
                    end else begin
                        b = expQ.pop_front();
                        check("beat-data", dataOut, b.data);
                        check("beat-last", BW'(outLast), BW'(b.last));
                    end
                end
                if (finished) finCnt++;
                if (error) errCnt++;
                holdPrev = outValid && !outReady;
                prevData = dataOut;
                prevLast = outLast;
                prevValid = outValid;
            end
        end
    end

    task automatic runRoute(input vec_t v);
        int  stallSeen;
        bit  doneFlag;
        beatCnt = 0;
        finCnt = 0;
        errCnt = 0;
        firstData = '0;
        outReady = (v.stall == 0);
        if (v.expErr == 0 && v.s != v.f) pushExpected(v.s, v.f, v.lanes);
        @(posedge clk); #1;
        routeEn = 1'b1;
        startAddr = AW'(v.s);
        finalAddr = AW'(v.f);
        laneCount = CW'(v.lanes);
        @(posedge clk); #1;
        routeEn = 1'b0;
        startAddr = AW'($urandom_range(0, DEPTH - 1));
        finalAddr = AW'($urandom_range(0, DEPTH - 1));
        laneCount = CW'($urandom_range(0, 15));
        check("busy-start", BW'(busy), BW'(v.expErr == 0));
        stallSeen = 0;
        doneFlag = 1'b0;
        for (int i = 0; i < 3000 && !doneFlag; i++) begin
            @(posedge clk); #1;
            if (!outReady && outValid) begin
                stallSeen++;
                if (stallSeen > v.stall) outReady = 1'b1;
            end
            if (v.poke > 0 && i == v.poke) begin
                routeEn = 1'b1;
                laneCount = '0;
                startAddr = AW'(5);
                finalAddr = AW'(5);
            end else begin
                routeEn = 1'b0;
            end
            if (finCnt + errCnt > 0) doneFlag = 1'b1;
        end
        if (!doneFlag) begin
            tests++;
            fails++;
            $display("FAIL route-timeout: no finished/error within 3000 cycles, expected one");
        end
        repeat (4) @(posedge clk);
        #1;
        check("beat-count", BW'(beatCnt), BW'(v.expBeats));
        check("finished-count", BW'(finCnt), BW'(v.expFin));
        check("error-count", BW'(errCnt), BW'(v.expErr));
        check("beats-pending", BW'(expQ.size()), BW'(0));
        check("busy-end", BW'(busy), BW'(1'b0));
        if (v.chkFirst) check("first-beat", firstData, v.first);
        expQ.delete();
        outReady = 1'b1;
    endtask

    initial begin
        int waited;
        vecs.push_back(vec_t'{0, 81, 9, 0, 0, 9, 1, 0, 1'b1, 72'h080706050403020100});
        vecs.push_back(vec_t'{10, 15, 4, 0, 0, 2, 1, 0, 1'b1, 72'h00000000000D0C0B0A});
        vecs.push_back(vec_t'{0, 18, 9, 5, 0, 2, 1, 0, 1'b0, 72'h0});
        vecs.push_back(vec_t'{5, 5, 3, 0, 0, 0, 1, 0, 1'b0, 72'h0});
        vecs.push_back(vec_t'{3, 7, 0, 0, 0, 0, 0, 1, 1'b0, 72'h0});
        vecs.push_back(vec_t'{3, 7, 10, 0, 0, 0, 0, 1, 1'b0, 72'h0});
`ifdef ROUTER_WRAP_EN
        vecs.push_back(vec_t'{126, 2, 4, 0, 0, 1, 1, 0, 1'b1, 72'h0000000000001007F7E - 72'h0000000000001000000 + 72'h0000000000001000000});
`else
        vecs.push_back(vec_t'{126, 2, 4, 0, 0, 0, 0, 1, 1'b0, 72'h0});
`endif
        vecs.push_back(vec_t'{40, 47, 1, 0, 3, 7, 1, 0, 1'b1, 72'h000000000000000028});
        vecs.push_back(vec_t'{100, 127, 9, 0, 0, 3, 1, 0, 1'b0, 72'h0});
        vecs.push_back(vec_t'{60, 69, 2, 3, 0, 5, 1, 0, 1'b1, 72'h000000000000003D3C});

        repeat (3) @(posedge clk);
        #1;
        check("reset-outValid", BW'(outValid), BW'(1'b0));
        check("reset-outLast", BW'(outLast), BW'(1'b0));
        check("reset-busy", BW'(busy), BW'(1'b0));
        check("reset-finished", BW'(finished), BW'(1'b0));
        check("reset-error", BW'(error), BW'(1'b0));
        check("reset-dataOut", dataOut, BW'(0));
        nrst = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            @(posedge clk); #1;
            writeEn = 1'b1;
            writeAddr = AW'(a);
            dataIn = DW'(a);
            model[a] = DW'(a);
        end
        @(posedge clk); #1;
        writeEn = 1'b0;

        for (int t = 0; t < vecs.size(); t++) begin
            runRoute(vecs[t]);
        end

        outReady = 1'b0;
        @(posedge clk); #1;
        routeEn = 1'b1;
        startAddr = AW'(0);
        finalAddr = AW'(18);
        laneCount = CW'(9);
        @(posedge clk); #1;
        routeEn = 1'b0;
        waited = 0;
        while (!outValid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rst-pre-valid", BW'(outValid), BW'(1'b1));
        nrst = 1'b0;
        #1;
        check("rst-outValid", BW'(outValid), BW'(1'b0));
        check("rst-outLast", BW'(outLast), BW'(1'b0));
        check("rst-busy", BW'(busy), BW'(1'b0));
        check("rst-finished", BW'(finished), BW'(1'b0));
        check("rst-error", BW'(error), BW'(1'b0));
        check("rst-dataOut", dataOut, BW'(0));
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        outReady = 1'b1;
        expQ.delete();
        runRoute(vec_t'{0, 9, 9, 0, 0, 1, 1, 0, 1'b1, 72'h080706050403020100});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_router.md
WINDOW_ROUTER -- requirements
Module: window_router

Interface
REQ-001 SHALL have parameter DataWidth, default 8, element width in bits.
REQ-002 SHALL have parameter Depth, default 128, buffer entries; AddrWidth = $clog2(Depth).
REQ-003 SHALL have parameter MaxWidth, default 9, output lanes per beat; CntWidth = $clog2(MaxWidth+1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports writeEn  input  1; writeAddr  input  AddrWidth; dataIn  input  DataWidth: buffer write port.
REQ-007 SHALL have ports routeEn  input  1; startAddr, finalAddr  input  AddrWidth; laneCount  input  CntWidth: route request, with finalAddr exclusive.
REQ-008 SHALL have ports outValid  output  1; outReady  input  1; dataOut  output  MaxWidth*DataWidth; outLast  output  1: beat stream.
REQ-009 SHALL have ports busy  output  1; finished  output  1; error  output  1: status.

Function
REQ-010 SHALL write dataIn to buffer[writeAddr] on any cycle with writeEn=1, including while routing; a same-cycle read of that address SHALL return the old data.
REQ-011 SHALL sample routeEn only in IDLE; routeEn while busy SHALL be ignored.
REQ-012 SHALL latch startAddr, finalAddr and laneCount on an accepted routeEn; later input changes SHALL not affect the route.
REQ-013 SHALL use a FSM with states IDLE, READ, OUT, DONE.
REQ-014 FSM transitions: IDLE->READ on a valid request; READ->OUT after laneCount elements, or after the remaining elements if fewer; OUT->READ on handshake if elements remain; OUT->DONE on handshake of the last beat; DONE->IDLE after one cycle.
REQ-015 Route length L SHALL be finalAddr-startAddr; elements SHALL be read in ascending address order, one per cycle, with 1-cycle synchronous read latency.
REQ-016 Element k of a beat SHALL occupy dataOut[k*DataWidth +: DataWidth] (lane 0 at the LSBs); unused lanes SHALL be zero.
REQ-017 For a beat of n elements, outValid SHALL assert n+2 cycles after the routeEn cycle (first beat) or after the previous handshake cycle (later beats).
REQ-018 Handshake SHALL occur when outValid=1 and outReady=1; while outValid=1 and outReady=0, dataOut, outLast and outValid SHALL hold stable.
REQ-019 outLast SHALL be 1 only with the final beat of a route.
REQ-020 busy SHALL be 1 from the cycle after an accepted routeEn until the cycle finished is 1, inclusive; it SHALL be 0 from the following cycle.
REQ-021 finished SHALL pulse for one cycle, in DONE, the cycle after the last handshake.
REQ-022 If laneCount=0 or laneCount>MaxWidth, the block SHALL pulse error for one cycle, emit no beats and stay in IDLE.
REQ-023 If startAddr==finalAddr, the block SHALL emit no beats and SHALL pulse finished the cycle after routeEn.

Reset
REQ-024 On nrst=0, the FSM SHALL go to IDLE and outValid, outLast, busy, finished, error and dataOut SHALL go to 0, asynchronously, including mid-route.
REQ-025 Buffer contents SHALL not be cleared by reset.
REQ-026 The first routeEn after nrst deasserts SHALL be accepted normally.

Configuration
REQ-027 With macro ROUTER_WRAP_EN defined, finalAddr<startAddr SHALL give L=Depth-startAddr+finalAddr, and addresses SHALL wrap from Depth-1 to 0.
REQ-028 Without ROUTER_WRAP_EN, finalAddr<startAddr SHALL pulse error for one cycle and emit no beats.

Verification
REQ-029 Write 0x00..0x50 to addresses 0..80; route 0->81, laneCount=9, outReady=1 -> 9 beats; beat0 dataOut=0x080706050403020100; outLast on beat 9; finished pulses once.
REQ-030 Same buffer; route 10->15, laneCount=4 -> beat0 low 32 bits 0x0D0C0B0A with the rest zero; beat1 lane0 0x0E with the rest zero and outLast=1.
REQ-031 Route 0->18, laneCount=9, outReady held low 5 cycles on beat0 -> outValid and dataOut stable for all 5 cycles; 2 beats total.
REQ-032 laneCount=0 -> one error pulse, no outValid; route 5->5 -> one finished pulse, no outValid.
REQ-033 With ROUTER_WRAP_EN, buffer[n]=n, route 126->2, laneCount=4 -> one beat 0x01007F7E with outLast=1; without the macro -> one error pulse.
REQ-034 nrst asserted while outValid=1 -> all outputs 0 immediately; after release, route 0->9 completes as in REQ-029 beat0.
